// File: rtl/priority_coder.sv
// Registered 4-input priority encoder: a4 > a3 > a2 > a1, one-cycle latency.
// Optional `multi` flag (two or more requests active) when PRIORITY_CODER_MULTI_EN is defined.
module priority_coder (
    input  logic clk,
    input  logic rst,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic a4,
    output logic x,
    output logic y,
    output logic valid
`ifdef PRIORITY_CODER_MULTI_EN
    ,
    output logic multi
`endif
);

    typedef struct packed {
        logic [1:0] code;
        logic       valid;
`ifdef PRIORITY_CODER_MULTI_EN
        logic       multi;
`endif
    } res_t;

    res_t nxt, cur;

    // Priority chain: lower requests are never evaluated while a higher one is
    // set, so an unknown lower input cannot leak into the code.
    always_comb begin
        nxt = '0;
        if (a4)      nxt.code = 2'd3;
        else if (a3) nxt.code = 2'd2;
        else if (a2) nxt.code = 2'd1;
        else         nxt.code = 2'd0;
        nxt.valid = a4 | a3 | a2 | a1;
`ifdef PRIORITY_CODER_MULTI_EN
        nxt.multi = (a4 & (a3 | a2 | a1)) | (a3 & (a2 | a1)) | (a2 & a1);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= '0;
        else     cur <= nxt;
    end

    assign x     = cur.code[1];
    assign y     = cur.code[0];
    assign valid = cur.valid;
`ifdef PRIORITY_CODER_MULTI_EN
    assign multi = cur.multi;
`endif

endmodule

// File: tb/tb_priority_coder.sv
// Randomized self-checking bench for priority_coder against a behavioural model.
// Also checks `multi` when built with PRIORITY_CODER_MULTI_EN.
module tb_priority_coder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a1 = 1'b0, a2 = 1'b0, a3 = 1'b0, a4 = 1'b0;
    logic x, y, valid;
`ifdef PRIORITY_CODER_MULTI_EN
    logic multi;
`endif

    int n_chk = 0;
    int n_err = 0;

    priority_coder dut (
        .clk   (clk),
        .rst   (rst),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .a4    (a4),
        .x     (x),
        .y     (y),
        .valid (valid)
`ifdef PRIORITY_CODER_MULTI_EN
        ,
        .multi (multi)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: code = index of highest set request, valid = any set, multi = 2+ set.
    function automatic int ref_code(input logic [3:0] req);
        int hi = 0;
        for (int i = 0; i < 4; i++) if (req[i]) hi = i;
        return hi;
    endfunction

    function automatic int ref_multi(input logic [3:0] req);
        int n = 0;
        for (int i = 0; i < 4; i++) if (req[i]) n++;
        return (n >= 2) ? 1 : 0;
    endfunction

    task automatic check_out(input string tag, input logic [3:0] req);
        chk({tag, ".code"}, int'({x, y}), ref_code(req));
        chk({tag, ".valid"}, int'(valid), (req != 4'd0) ? 1 : 0);
`ifdef PRIORITY_CODER_MULTI_EN
        chk({tag, ".multi"}, int'(multi), ref_multi(req));
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".code"}, int'({x, y}), 0);
        chk({tag, ".valid"}, int'(valid), 0);
`ifdef PRIORITY_CODER_MULTI_EN
        chk({tag, ".multi"}, int'(multi), 0);
`endif
    endtask

    task automatic drive(input logic [3:0] req);
        {a4, a3, a2, a1} = req;
    endtask

    // Drive on the falling edge, sample 1 ns after the next rising edge.
    task automatic step(input string tag, input logic [3:0] req);
        @(negedge clk);
        drive(req);
        @(posedge clk);
        #1;
        check_out(tag, req);
    endtask

    logic [3:0] req;
    logic [3:0] combos [4];

    initial begin
        // Reset held with a4 active and clocks running.
        drive(4'b1000);
        #1;
        check_zero("rst_async");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;

        // One-hot sweep.
        for (int i = 0; i < 4; i++) begin
            req = 4'b0001 << i;
            step("onehot", req);
        end

        // Idle versus a1 alone.
        step("idle", 4'b0000);
        step("a1_only", 4'b0001);

        // Multi-request patterns.
        combos[0] = 4'b1111;
        combos[1] = 4'b0110;
        combos[2] = 4'b0101;
        combos[3] = 4'b1001;
        for (int i = 0; i < 4; i++) step("combo", combos[i]);

        // Glitch on a4 between edges must not reach the outputs.
        step("pre_glitch", 4'b0000);
        #2 a4 = 1'b1;
        #2 a4 = 1'b0;
        #1 check_out("glitch_mid", 4'b0000);
        @(posedge clk);
        #1 check_out("glitch_after", 4'b0000);

        // Mid-cycle reset clears outputs at once, and the pending sample is dropped.
        step("pre_rst", 4'b1000);
        @(negedge clk);
        drive(4'b0100);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid");
        @(posedge clk);
        #1 check_zero("rst_mid_edge");
        @(negedge clk);
        drive(4'b0000);
        rst = 1'b0;
        @(posedge clk);
        #1 check_out("rst_release", 4'b0000);
        step("post_rst", 4'b0010);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            req = 4'($urandom_range(0, 15));
            step("rand", req);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
